// File: rtl/gf233_mul_seq_if.sv
// rtl/gf233_mul_seq_if.sv - request/result bundle for the sequential GF(2^233) multiplier
//
// Signals:
//   start  master->slave  request, sampled by the multiplier only when idle
//   a, b   master->slave  233-bit operands, bit i = coefficient of x^i
//   busy   slave->master  operation in progress
//   done   slave->master  one-cycle pulse, c valid in that cycle
//   c      slave->master  reduced product a*b mod x^233+x^74+1
`timescale 1ns/1ps
interface gf233_mul_seq_if;
    logic         start;
    logic [232:0] a;
    logic [232:0] b;
    logic         busy;
    logic         done;
    logic [232:0] c;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input c);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output c);
endinterface

// File: rtl/gf233_mul_seq.sv
// rtl/gf233_mul_seq.sv - sequential GF(2^233) multiplier over a single 29x29 carry-less core
//
// Modules:
//   mult29        29x29 carry-less multiplier, product registered (1-cycle latency)
//   gf233_mul_seq limb-serial controller, 522-bit accumulator, two-step fold mod
//                 f(x) = x^233 + x^74 + 1
//
// gf233_mul_seq ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts any operation in flight
//   bus    gf233_mul_seq_if.slave: start/a/b in, busy/done/c out
//
// Build option:
//   GF233_MUL_ZERO_SKIP_EN  when defined, rows whose A limb is zero are skipped,
//                           giving latency 9*nz+3 (nz = nonzero A limbs); results
//                           are identical to the default fixed-84-cycle build.
`timescale 1ns/1ps
module mult29 #(
    parameter int W = 29
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);
    function automatic logic [2*W-1:0] clmul(input logic [W-1:0] u, input logic [W-1:0] v);
        logic [2*W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) begin
            if (v[k]) r = r ^ ({{W{1'b0}}, u} << k);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) p <= '0;
        else        p <= clmul(x, y);
    end
endmodule

module gf233_mul_seq #(
    parameter int LIMB_W = 29,
    parameter int NLIMB  = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    gf233_mul_seq_if.slave bus
);
    localparam int M  = 233;
    localparam int K  = 74;
    localparam int PW = NLIMB * LIMB_W;      // padded operand width (261)
    localparam int AW = 2 * PW;              // accumulator width (522)
    localparam int DW = 2 * LIMB_W;          // core product width (58)
    localparam logic [8:0] SHIFT_STEP = 9'(LIMB_W);
    localparam logic [3:0] LAST = 4'(NLIMB - 1);

    typedef enum logic [2:0] {IDLE, MULT, DRAIN, REDUCE, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   a_reg;
    logic [PW-1:0]   b_reg;
    logic [3:0]      i_idx;
    logic [3:0]      j_idx;
    logic            tag_valid;
    logic [8:0]      tag_shift;
    logic [AW-1:0]   acc;
    logic            busy_q;
    logic            done_q;
    logic [M-1:0]    c_q;

    logic [PW-1:0]   a_pad_in;
    logic [PW-1:0]   b_pad_in;
    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [DW-1:0]   mult_p;

    assign a_pad_in = {{(PW-M){1'b0}}, bus.a};
    assign b_pad_in = {{(PW-M){1'b0}}, bus.b};
    assign a_limb   = a_reg[int'(i_idx)*LIMB_W +: LIMB_W];
    assign b_limb   = b_reg[int'(j_idx)*LIMB_W +: LIMB_W];

    mult29 #(.W(LIMB_W)) u_mult29 (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (a_limb),
        .y     (b_limb),
        .p     (mult_p)
    );

`ifdef GF233_MUL_ZERO_SKIP_EN
    function automatic logic [NLIMB-1:0] nz_mask(input logic [PW-1:0] v);
        logic [NLIMB-1:0] m;
        for (int k = 0; k < NLIMB; k++) m[k] = |v[k*LIMB_W +: LIMB_W];
        return m;
    endfunction

    // {found, index} of the lowest nonzero row at or above 'from'.
    // Scanning downwards lets the lowest qualifying row win.
    function automatic logic [4:0] next_row(input logic [NLIMB-1:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int k = NLIMB - 1; k >= 0; k--) begin
            if (k >= from && m[k]) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    logic [4:0] row_first;
    logic [4:0] row_next;
    assign row_first = next_row(nz_mask(a_pad_in), 0);
    assign row_next  = next_row(nz_mask(a_reg), int'(i_idx) + 1);
`endif

    // Fold mod x^233+x^74+1: x^(233+k) = x^k*(x^74+1). The first pass leaves at most
    // 73 bits above x^232 (from h<<74); the second pass lands entirely below x^233.
    logic [M-2:0]  fold_h;
    logic [M-1:0]  fold_r;
    logic [72:0]   fold_h2;
    logic [M-1:0]  fold_c;

    always_comb begin
        fold_h  = acc[2*M-2:M];
        fold_r  = acc[M-1:0] ^ {1'b0, fold_h} ^ {fold_h[M-K-1:0], {K{1'b0}}};
        fold_h2 = fold_h[M-2:M-K];
        fold_c  = fold_r ^ {{(M-73){1'b0}}, fold_h2} ^ {{(M-73-K){1'b0}}, fold_h2, {K{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            tag_valid <= 1'b0;
            tag_shift <= '0;
            acc       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_q       <= '0;
        end else begin
            // Tag travels alongside the registered product so the shift matches
            // the limb pair that produced it.
            tag_valid <= (state == MULT);
            tag_shift <= SHIFT_STEP * (9'(i_idx) + 9'(j_idx));
            if (tag_valid) acc <= acc ^ ({{(AW-DW){1'b0}}, mult_p} << tag_shift);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= a_pad_in;
                        b_reg  <= b_pad_in;
                        j_idx  <= '0;
                        acc    <= '0;
                        busy_q <= 1'b1;
`ifdef GF233_MUL_ZERO_SKIP_EN
                        if (row_first[4]) begin
                            i_idx <= row_first[3:0];
                            state <= MULT;
                        end else begin
                            i_idx <= '0;
                            state <= DRAIN;
                        end
`else
                        i_idx <= '0;
                        state <= MULT;
`endif
                    end
                end
                MULT: begin
                    if (j_idx == LAST) begin
                        j_idx <= '0;
`ifdef GF233_MUL_ZERO_SKIP_EN
                        if (row_next[4]) i_idx <= row_next[3:0];
                        else             state <= DRAIN;
`else
                        if (i_idx == LAST) state <= DRAIN;
                        else               i_idx <= i_idx + 4'd1;
`endif
                    end else begin
                        j_idx <= j_idx + 4'd1;
                    end
                end
                DRAIN: begin
                    state <= REDUCE;
                end
                REDUCE: begin
                    c_q    <= fold_c;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;
endmodule

// File: tb/tb_gf233_mul_seq.sv
// tb/tb_gf233_mul_seq.sv - self-checking bench for gf233_mul_seq
`timescale 1ns/1ps
module tb_gf233_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf233_mul_seq_if bus ();
    gf233_mul_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [232:0] act, input logic [232:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Schoolbook carry-less product, then reduce one high term at a time
    // using x^k = x^(k-233) + x^(k-159) for k >= 233.
    function automatic logic [232:0] gf_mul(input logic [232:0] x, input logic [232:0] y);
        logic [464:0] p;
        p = '0;
        for (int k = 0; k < 233; k++)
            if (y[k]) p = p ^ ({232'd0, x} << k);
        for (int k = 464; k >= 233; k--) begin
            if (p[k]) begin
                p[k]       = 1'b0;
                p[k - 233] = ~p[k - 233];
                p[k - 159] = ~p[k - 159];
            end
        end
        return p[232:0];
    endfunction

    function automatic int exp_latency(input logic [232:0] x);
`ifdef GF233_MUL_ZERO_SKIP_EN
        logic [260:0] xp;
        int nz;
        xp = {28'd0, x};
        nz = 0;
        for (int k = 0; k < 9; k++) if (xp[29*k +: 29] != 29'd0) nz++;
        return 9 * nz + 3;
`else
        return (x == x) ? 84 : 84;
`endif
    endfunction

    function automatic logic [232:0] rand233();
        logic [255:0] t;
        for (int w = 0; w < 8; w++) t[32*w +: 32] = $urandom;
        return t[232:0];
    endfunction

    // Cycle-level reference: cnt is the cycle number within the current
    // operation (1 = first cycle after start is accepted), 0 when idle.
    int           cnt = 0;
    int           lat = 84;
    logic [232:0] exp_c = '0;
    logic [232:0] pend = '0;
    bit           live = 1'b0;

    always @(posedge clk) begin
        live = 1'b1;
        if (!rst_n) begin
            cnt   = 0;
            exp_c = '0;
        end else if (cnt == 0) begin
            if (bus.start) begin
                cnt  = 1;
                lat  = exp_latency(bus.a);
                pend = gf_mul(bus.a, bus.b);
                if (cnt == lat) exp_c = pend;
            end
        end else if (cnt == lat) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == lat) exp_c = pend;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy", {232'd0, bus.busy}, {232'd0, (cnt >= 1 && cnt < lat)});
            chk("done", {232'd0, bus.done}, {232'd0, (cnt != 0 && cnt == lat)});
            chk("c", bus.c, exp_c);
            if (bus.done) chk("acc_hi", {176'd0, dut.acc[521:465]}, 233'd0);
        end
    end

    task automatic run_op(input logic [232:0] x, input logic [232:0] y,
                          input int inj_at, input int rst_at,
                          output logic [232:0] res, output int lat_seen);
        int n;
        @(negedge clk);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        lat_seen = -1;
        res = '0;
        while (n <= 200) begin
            if (bus.done) begin
                lat_seen = n;
                res = bus.c;
                break;
            end
            if (n == inj_at) begin
                bus.a = ~x;
                bus.b = y ^ 233'd12345;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                lat_seen = 0;
                break;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (lat_seen < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout act=no_done exp=done_within_200");
        end
    endtask

    logic [232:0] one;
    logic [232:0] ra;
    logic [232:0] rb;
    logic [232:0] res;
    int           ls;

    initial begin
        one = 233'd1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {232'd0, bus.busy}, 233'd0);
        chk("rst_done", {232'd0, bus.done}, 233'd0);
        chk("rst_c", bus.c, 233'd0);
        rst_n = 1'b1;

        run_op(one, one, 0, 0, res, ls);
        chk("one_c", res, one);
`ifndef GF233_MUL_ZERO_SKIP_EN
        chk_int("one_lat", ls, 84);
`endif

        run_op(one << 232, one << 1, 0, 0, res, ls);
        chk("x232_x", res, (one << 74) | one);

        run_op(one << 232, one << 232, 0, 0, res, ls);
        chk("x232_sq", res, (one << 231) | (one << 146) | (one << 72));

        ra = rand233();
        rb = rand233();
        run_op(ra, rb, 40, 0, res, ls);
        chk("ignore_start_c", res, gf_mul(ra, rb));

        run_op(rand233(), rand233(), 0, 50, res, ls);
        chk("abort_busy", {232'd0, bus.busy}, 233'd0);
        chk("abort_done", {232'd0, bus.done}, 233'd0);
        chk("abort_c", bus.c, 233'd0);
        ra = rand233() | one;
        rb = rand233();
        run_op(ra, rb, 0, 0, res, ls);
        chk("post_abort_c", res, gf_mul(ra, rb));
        chk_int("post_abort_lat", ls, exp_latency(ra));

`ifdef GF233_MUL_ZERO_SKIP_EN
        rb = rand233();
        run_op(one, rb, 0, 0, res, ls);
        chk_int("skip_one_lat", ls, 12);
        chk("skip_one_c", res, rb);
        run_op(233'd0, rand233(), 0, 0, res, ls);
        chk_int("skip_zero_lat", ls, 3);
        chk("skip_zero_c", res, 233'd0);
        run_op(~233'd0, one, 0, 0, res, ls);
        chk_int("skip_full_lat", ls, 84);
        chk("skip_full_c", res, ~233'd0);
`else
        run_op(233'd0, rand233(), 0, 0, res, ls);
        chk_int("zero_lat", ls, 84);
        chk("zero_c", res, 233'd0);
`endif

        for (int t = 0; t < 300; t++) begin
            ra = rand233();
            rb = rand233();
            if (t % 7 == 3) ra = ra & (rand233() << $urandom_range(0, 200));
            run_op(ra, rb, 0, 0, res, ls);
            chk("rand_c", res, gf_mul(ra, rb));
            chk_int("rand_lat", ls, exp_latency(ra));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
